// File: rtl/crc_manager_pkg.sv
// Shared constants for the SD-card CRC manager: polynomials, init values and
// the end bit appended to the command CRC byte.
package crc_manager_pkg;

   localparam int          CRC7_W      = 7;
   localparam int          CRC16_W     = 16;
   localparam logic [6:0]  CRC7_POLY   = 7'h09;
   localparam logic [15:0] CRC16_POLY  = 16'h1021;
   localparam logic [6:0]  CRC7_INIT   = 7'h00;
   localparam logic [15:0] CRC16_INIT  = 16'h0000;
   localparam logic        CRC_END_BIT = 1'b1;

endpackage : crc_manager_pkg

// File: rtl/crc_lfsr_serial.sv
// Generic serial MSB-first CRC LFSR, one bit per falling clock edge,
// no reflection and no final XOR.
module crc_lfsr_serial #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = '0,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] crc
);

   logic             fb_s;
   logic [WIDTH-1:0] crc_next_s;

   // Next-state of the register for the incoming bit.
   always_comb begin
      fb_s       = din ^ crc[WIDTH-1];
      crc_next_s = {crc[WIDTH-2:0], 1'b0};
      if (fb_s) begin
         crc_next_s = crc_next_s ^ POLY;
      end else begin
         crc_next_s = crc_next_s;
      end
   end

   // CRC state register; SPI data is launched on rising and sampled on falling edges.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         crc <= INIT;
      end else if (en) begin
         crc <= crc_next_s;
      end else begin
         crc <= crc;
      end
   end

endmodule : crc_lfsr_serial

// File: rtl/crc_manager.sv
// Runs the SD command CRC7 and data CRC16 side by side on the same serial bit
// stream; a new frame is started by pulsing reset.
module crc_manager
   import crc_manager_pkg::*;
(
   input  logic        spi_clk,
   input  logic        reset,
   input  logic        en,
   input  logic        mosi,
   output logic [7:0]  crc8,
   output logic [15:0] crc16
);

   logic [CRC7_W-1:0] crc7_s;

   crc_lfsr_serial #(
      .WIDTH (CRC7_W),
      .POLY  (CRC7_POLY),
      .INIT  (CRC7_INIT)
   ) u_crc7 (
      .clk   (spi_clk),
      .reset (reset),
      .en    (en),
      .din   (mosi),
      .crc   (crc7_s)
   );

   crc_lfsr_serial #(
      .WIDTH (CRC16_W),
      .POLY  (CRC16_POLY),
      .INIT  (CRC16_INIT)
   ) u_crc16 (
      .clk   (spi_clk),
      .reset (reset),
      .en    (en),
      .din   (mosi),
      .crc   (crc16)
   );

   // Command CRC byte as sent on the wire: CRC7 followed by the end bit.
   assign crc8 = {crc7_s, CRC_END_BIT};

endmodule : crc_manager

// File: tb/tb_crc_manager.sv
// Directed bench for crc_manager using known SD-card and XMODEM CRC vectors.
module tb_crc_manager;

   logic        spi_clk;
   logic        reset;
   logic        en;
   logic        mosi;
   logic [7:0]  crc8;
   logic [15:0] crc16;
   logic        clk_run;
   int          checks;
   int          errors;

   crc_manager dut (
      .spi_clk (spi_clk),
      .reset   (reset),
      .en      (en),
      .mosi    (mosi),
      .crc8    (crc8),
      .crc16   (crc16)
   );

   // Gated free-running clock so the bench can hold the clock static.
   always #5 begin
      if (clk_run) spi_clk = ~spi_clk;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         @(posedge spi_clk);
         mosi = b[i];
         en   = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   task automatic idle_after;
      @(posedge spi_clk);
      en = 1'b0;
      #1;
   endtask

   task automatic pulse_reset;
      @(posedge spi_clk);
      en    = 1'b0;
      reset = 1'b0;
      #1;
      check8 ("rst_crc8", crc8, 8'h01);
      check16("rst_crc16", crc16, 16'h0000);
      @(posedge spi_clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] cmd0 [5];
      logic [7:0] cmd8 [5];
      checks  = 0;
      errors  = 0;
      spi_clk = 1'b1;
      clk_run = 1'b0;
      reset   = 1'b0;
      en      = 1'b0;
      mosi    = 1'b0;
      cmd0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      cmd8 = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};

      #20;
      check8 ("init_crc8", crc8, 8'h01);
      check16("init_crc16", crc16, 16'h0000);
      reset = 1'b1;
      #20;
      check8 ("release_crc8", crc8, 8'h01);
      check16("release_crc16", crc16, 16'h0000);

      clk_run = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(cmd0[i]);
      idle_after();
      check8("cmd0_crc8", crc8, 8'h95);

      pulse_reset();
      for (int i = 0; i < 5; i++) send_byte(cmd8[i]);
      idle_after();
      check8("cmd8_crc8", crc8, 8'h87);

      pulse_reset();
      for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
      idle_after();
      check16("ascii_crc16", crc16, 16'h31C3);

      pulse_reset();
      for (int i = 0; i < 512; i++) send_byte(8'hFF);
      idle_after();
      check16("ff512_crc16", crc16, 16'h7FA1);

      pulse_reset();
      send_byte(8'h40);
      idle_after();
      check8 ("byte40_crc8", crc8, 8'hC9);
      check16("byte40_crc16", crc16, 16'h48C4);
      for (int i = 0; i < 16; i++) begin
         @(posedge spi_clk);
         mosi = ~mosi;
      end
      #1;
      check8 ("hold_crc8", crc8, 8'hC9);
      check16("hold_crc16", crc16, 16'h48C4);

      send_bits(8'hA5, 4);
      @(posedge spi_clk);
      reset = 1'b0;
      #1;
      check8 ("midbyte_rst_crc8", crc8, 8'h01);
      check16("midbyte_rst_crc16", crc16, 16'h0000);
      repeat (3) @(posedge spi_clk);
      #1;
      check8 ("held_rst_crc8", crc8, 8'h01);
      check16("held_rst_crc16", crc16, 16'h0000);
      en    = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(cmd0[i]);
      idle_after();
      check8("restart_cmd0_crc8", crc8, 8'h95);

      clk_run = 1'b0;
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_crc_manager
